// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and the cache controller that drives it.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int DEF_ADDR_W      = 8;
   localparam int DEF_DATA_W      = 8;
   localparam int DEF_WAIT_CYCLES = 4;

   localparam logic MRW_WRITE = 1'b1;
   localparam logic MRW_READ  = 1'b0;

endpackage

// File: rtl/mem_wait_counter.sv
// 8-bit wait-state down-counter; term flags the last wait cycle (count==1).
module mem_wait_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic       term
);

   logic [7:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= 8'd0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != 8'd0)) begin
         count <= count - 8'd1;
      end
   end

   assign term = (count == 8'd1);

endmodule

// File: rtl/mem_responder.sv
// Wait-stated single-port memory answering cache-controller requests.
// Each access: WAIT_CYCLES wait states, one array cycle, one MReady cycle.
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MStrobe,
   input  logic              MRW,
   input  logic [ADDR_W-1:0] MAddr,
   input  logic [DATA_W-1:0] MDataIn,
   output logic [DATA_W-1:0] MDataOut,
   output logic              MReady,
   output logic              MBusy,
   output logic              MCollide
);

   generate
      if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 255)) begin : g_bad_wait
         $error("mem_responder: WAIT_CYCLES must be in 1..255");
      end
   endgenerate

   localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);

   state_t            state;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_term;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   assign cnt_load = (state == IDLE) && MStrobe;
   assign cnt_dec  = (state == WAIT);

   mem_wait_counter u_wait_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (WAIT_LOAD),
      .dec      (cnt_dec),
      .term     (cnt_term)
   );

   // Array is never reset; an async reset forces state to IDLE so an aborted write never lands.
   always_ff @(posedge clk) begin
      if ((state == ACCESS) && (rw == MRW_WRITE)) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         rw       <= 1'b0;
         addr     <= '0;
         wdata    <= '0;
         MDataOut <= '0;
         MReady   <= 1'b0;
         MBusy    <= 1'b0;
         MCollide <= 1'b0;
      end else begin
         MReady   <= 1'b0;
         MCollide <= 1'b0;
         case (state)
            IDLE: begin
               if (MStrobe) begin
                  rw    <= MRW;
                  addr  <= MAddr;
                  wdata <= MDataIn;
                  MBusy <= 1'b1;
                  state <= WAIT;
               end
            end
            WAIT: begin
               MCollide <= MStrobe;
               if (cnt_term) begin
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               MCollide <= MStrobe;
               if (rw == MRW_READ) begin
                  MDataOut <= mem[addr];
               end
               MReady <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               MCollide <= MStrobe;
               MBusy    <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
